avalon_arb: RTL and testbench
=============================

Name: avalon_arb

Overview:
- Round-robin arbiter that shares one Avalon slave port (address/readdata/writedata/write/chipselect) among NREQ requesting masters inside the UART test/peripheral environment.
- Serialises single-beat reads and writes, routes readdata back to the winning requester, and keeps a rotating priority pointer so no requester starves.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- m_req  input  NREQ  per-requester transaction request; held until m_ack.
- m_write  input  NREQ  per-requester direction, 1 = write, 0 = read; held with m_req.
- m_addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- m_wdata  input  NREQ*DW  packed write data, same packing.
- m_ack  output  NREQ  one-hot, one-cycle completion pulse to the winner.
- m_rdata  output  DW  read data, shared by all requesters, valid when its m_rvalid bit is set.
- m_rvalid  output  NREQ  one-hot read-data-valid, coincident with m_ack for reads.
- s_address  output  AW  slave address.
- s_writedata  output  DW  slave write data.
- s_write  output  1  slave write strobe.
- s_chipselect  output  1  slave select; the access strobe.
- s_readdata  input  DW  slave read data, valid exactly 1 cycle after a read-access cycle (fixed read latency 1).

Behaviour:
- Reset (async, rstn=0): state=IDLE; m_ack, m_rvalid, s_chipselect, s_write = 0; s_address, s_writedata, m_rdata = 0; grant index = 0; priority pointer last = NREQ-1, so requester 0 has top priority after reset.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RDATA, ACK.
- IDLE:
  - If m_req == 0, stay in IDLE.
  - Otherwise pick winner w = first set bit scanning last+1, last+2, ... mod NREQ.
  - Latch w, m_addr[w], m_wdata[w], m_write[w] into s_address/s_writedata/s_write.
  - Drive s_chipselect=1 next cycle and go to ACCESS.
- ACCESS: s_chipselect=1 for exactly one cycle.
  - Write: s_write=1 this cycle; next state ACK.
  - Read: s_write=0; next state RDATA.
- RDATA: chipselect=0; capture s_readdata into m_rdata; next state ACK with m_rvalid[w] set.
- ACK: m_ack[w]=1 for one cycle; m_rvalid[w]=1 also if the access was a read; last <= w; next state IDLE.
- Latency from m_req rising (sampled in IDLE) to m_ack high:
  - Write: 3 cycles (IDLE, ACCESS, ACK).
  - Read: 4 cycles (IDLE, ACCESS, RDATA, ACK).
- Handshake: the requester samples m_ack at a rising edge and deasserts or changes m_req from that edge. The arbiter never samples m_req during ACCESS/RDATA/ACK, so a requester that re-raises req immediately is arbitrated on the next IDLE cycle.
- Request fields are latched at grant; later changes by the winner before m_ack are ignored. Changes by losers are allowed at any time.
- Simultaneous requests: exactly one grant per transaction. With all NREQ requesting continuously, grants follow strict rotation and each requester is served once per NREQ transactions.
- m_rdata holds its last value outside rvalid cycles. s_address/s_writedata hold their last value after the access; only chipselect qualifies them.
- Reset mid-transaction: the transaction is abandoned, no m_ack is issued, and the state returns to IDLE with pointer = NREQ-1.

Decomposition:
- Package avalon_arb_pkg:
  - state enum typedef (IDLE, ACCESS, RDATA, ACK);
  - localparam for read latency (1);
  - function clog2-based index width helper.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, binary index, any_req.
  - Reusable by other arbiters in the environment.

Test Plan:
- Single write: req[0]=1, write=1, addr=0x04, wdata=0xA5 -> one cycle of chipselect=1, write=1, address=0x04, writedata=0xA5; m_ack[0] pulses 3 cycles after request.
- Single read: req[2]=1, write=0, addr=0x08, slave returns 0x1234_5678 one cycle after chipselect -> m_rdata=0x12345678, m_rvalid[2]=m_ack[2]=1 in the same cycle, 4 cycles after request.
- Fairness: all four requesters hold req continuously for 8 transactions after reset -> grant order 0,1,2,3,0,1,2,3; never two chipselect cycles for the same requester within 4 transactions.
- Pointer wrap: last grant 3, then req=0b1001 -> grant 0; then req=0b1001 again -> grant 3.
- Reset mid-read: assert rstn=0 during RDATA -> no m_ack/m_rvalid; all outputs 0; first post-reset grant with req=0b1111 goes to requester 0.
- Field latch: requester 1 changes addr from 0x10 to 0x20 during ACCESS -> the slave sees only 0x10; a back-to-back re-request after m_ack is served next with the new address.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon round-robin arbiter.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA,
        ACK
    } state_e;

    localparam int RD_LAT = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avalon_arb_if.sv
// Requester-side and slave-side signals of the arbiter, bundled as one interface.
interface avalon_arb_if #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    m_req;
    logic [NREQ-1:0]    m_write;
    logic [NREQ*AW-1:0] m_addr;
    logic [NREQ*DW-1:0] m_wdata;
    logic [NREQ-1:0]    m_ack;
    logic [DW-1:0]      m_rdata;
    logic [NREQ-1:0]    m_rvalid;
    logic [AW-1:0]      s_address;
    logic [DW-1:0]      s_writedata;
    logic               s_write;
    logic               s_chipselect;
    logic [DW-1:0]      s_readdata;

    // Arbiter view.
    modport slave (
        input  m_req, m_write, m_addr, m_wdata, s_readdata,
        output m_ack, m_rdata, m_rvalid, s_address, s_writedata, s_write, s_chipselect
    );

    // Environment view: requesters plus the Avalon slave.
    modport master (
        output m_req, m_write, m_addr, m_wdata, s_readdata,
        input  m_ack, m_rdata, m_rvalid, s_address, s_writedata, s_write, s_chipselect
    );
endinterface

// File: rtl/avalon_arb_rr_pick.sv
// Combinational round-robin picker: first set request after the last winner.
module rr_pick
    import avalon_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);
    always_comb begin
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_i) + k) % NREQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
        any_o = |req_i;
    end
endmodule

// File: rtl/avalon_arb.sv
// Round-robin arbiter serialising single-beat reads/writes onto one Avalon slave.
module avalon_arb
    import avalon_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input logic         clk,
    input logic         rstn,
    avalon_arb_if.slave bus
);
    localparam int IW = idx_w(NREQ);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            write_q, write_d;
    logic            cs_q, cs_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_write;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i  (bus.m_req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // One-hot select of the candidate winner's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr  = bus.m_addr[i*AW +: AW];
                sel_wdata = bus.m_wdata[i*DW +: DW];
                sel_write = bus.m_write[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        cs_d     = 1'b0;
        ack_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    write_d = sel_write;
                    cs_d    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                write_d = 1'b0;
                if (write_q) begin
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                rdata_d  = bus.s_readdata;
                ack_d    = gnt_q;
                rvalid_d = gnt_q;
                state_d  = ACK;
            end
            ACK: begin
                last_d  = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            cs_q     <= 1'b0;
            ack_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            cs_q     <= cs_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.m_ack        = ack_q;
    assign bus.m_rvalid     = rvalid_q;
    assign bus.m_rdata      = rdata_q;
    assign bus.s_address    = addr_q;
    assign bus.s_writedata  = wdata_q;
    assign bus.s_write      = write_q;
    assign bus.s_chipselect = cs_q;
endmodule

// File: tb/tb_avalon_arb.sv
// Randomised and directed bench for avalon_arb against a transaction-level model.
module tb_avalon_arb;
    import avalon_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    avalon_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
    avalon_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Environment: slave memory, requester agents, observation logs.
    logic [DW-1:0]   mem [16];
    logic            pend;
    logic [3:0]      pend_a;
    bit              rand_on;
    bit              hold [NREQ];
    int              ack_log [$];
    int              ack_cyc [NREQ];
    logic [NREQ-1:0] rv_at_ack [NREQ];
    logic [AW-1:0]   cs_log [$];

    // Model: one transaction in flight, outputs predicted by cycles since grant.
    bit              m_active;
    int              m_since, m_lat, m_last, t_w;
    logic            t_wr;
    logic [AW-1:0]   t_addr;
    logic [DW-1:0]   t_wd, t_rd;
    logic [NREQ-1:0] e_ack, e_rv;
    logic            e_cs, e_wr;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wd, e_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic model_step();
        int j;
        if (!rstn) begin
            m_active = 0; m_last = NREQ - 1;
            e_ack = '0; e_rv = '0; e_cs = 1'b0; e_rdata = '0;
            return;
        end
        if (!m_active && bus.m_req != '0) begin
            t_w = 0;
            for (int k = 1; k <= NREQ; k++) begin
                j = (m_last + k) % NREQ;
                if (bus.m_req[j]) begin t_w = j; break; end
            end
            t_wr   = bus.m_write[t_w];
            t_addr = bus.m_addr[t_w*AW +: AW];
            t_wd   = bus.m_wdata[t_w*DW +: DW];
            t_rd   = mem[t_addr[5:2]];
            m_active = 1; m_since = 0;
        end
        e_ack = '0; e_rv = '0; e_cs = 1'b0;
        if (m_active) begin
            m_since++;
            m_lat = t_wr ? 2 : 2 + RD_LAT;
            if (m_since == 1) begin
                e_cs = 1'b1; e_addr = t_addr; e_wd = t_wd; e_wr = t_wr;
            end
            if (m_since == m_lat) begin
                e_ack[t_w] = 1'b1;
                if (!t_wr) begin e_rv[t_w] = 1'b1; e_rdata = t_rd; end
                m_last = t_w;
            end
            if (m_since > m_lat) m_active = 0;
        end
    endtask

    task automatic check_outputs();
        chk("m_ack", 64'(bus.m_ack), 64'(e_ack));
        chk("m_rvalid", 64'(bus.m_rvalid), 64'(e_rv));
        chk("s_chipselect", 64'(bus.s_chipselect), 64'(e_cs));
        chk("m_rdata", 64'(bus.m_rdata), 64'(e_rdata));
        if (e_cs) begin
            chk("s_address", 64'(bus.s_address), 64'(e_addr));
            chk("s_writedata", 64'(bus.s_writedata), 64'(e_wd));
            chk("s_write", 64'(bus.s_write), 64'(e_wr));
        end
        if (!rstn) begin
            chk("rst_s_address", 64'(bus.s_address), 64'd0);
            chk("rst_s_writedata", 64'(bus.s_writedata), 64'd0);
            chk("rst_s_write", 64'(bus.s_write), 64'd0);
        end
        if (bus.s_chipselect) cs_log.push_back(bus.s_address);
    endtask

    task automatic slave();
        bus.s_readdata = pend ? mem[pend_a] : $urandom;
        pend   = rstn && bus.s_chipselect && !bus.s_write;
        pend_a = bus.s_address[5:2];
        if (rstn && bus.s_chipselect && bus.s_write) mem[bus.s_address[5:2]] = bus.s_writedata;
    endtask

    task automatic rand_fields(input int i);
        bus.m_write[i]          = 1'($urandom_range(1));
        bus.m_addr[i*AW +: AW]  = $urandom;
        bus.m_wdata[i*DW +: DW] = $urandom;
    endtask

    task automatic agents();
        for (int i = 0; i < NREQ; i++) begin
            if (bus.m_ack[i]) begin
                ack_log.push_back(i);
                ack_cyc[i]   = cyc_n;
                rv_at_ack[i] = bus.m_rvalid;
                if (hold[i]) begin
                    if (rand_on) rand_fields(i);
                end else bus.m_req[i] = 1'b0;
            end else if (rand_on) begin
                if (!bus.m_req[i] && $urandom_range(3) == 0) begin
                    hold[i] = 1'($urandom_range(1));
                    rand_fields(i);
                    bus.m_req[i] = 1'b1;
                end else if (bus.m_req[i] && $urandom_range(7) == 0) rand_fields(i);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc_n++;
        check_outputs();
        slave();
        agents();
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.m_write[i]          = wr;
        bus.m_addr[i*AW +: AW]  = a;
        bus.m_wdata[i*DW +: DW] = d;
        bus.m_req[i]            = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int budget, input string nm);
        int b = 0;
        while (ack_log.size() < n && b < budget) begin tick(); b++; end
        if (ack_log.size() < n) begin
            total++; bad++;
            $display("FAIL %s: timeout, acks=%0d expected %0d", nm, ack_log.size(), n);
        end
    endtask

    task automatic wait_cs(input int n, input int budget, input string nm);
        int b = 0;
        while (cs_log.size() < n && b < budget) begin tick(); b++; end
        if (cs_log.size() < n) begin
            total++; bad++;
            $display("FAIL %s: timeout, cs=%0d expected %0d", nm, cs_log.size(), n);
        end
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while ((bus.m_req != '0 || m_active) && b < budget) begin tick(); b++; end
        if (bus.m_req != '0 || m_active) begin
            total++; bad++;
            $display("FAIL drain: timeout, m_req=%0h", bus.m_req);
        end
        tick(); tick();
    endtask

    initial begin
        int raise;
        int exp_ord [8];
        exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
        rstn = 1'b0;
        bus.m_req = '0; bus.m_write = '0; bus.m_addr = '0; bus.m_wdata = '0;
        bus.s_readdata = '0;
        pend = 1'b0; pend_a = '0; rand_on = 0;
        foreach (hold[i]) hold[i] = 0;
        foreach (mem[i]) mem[i] = $urandom;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Single write from requester 0.
        cs_log.delete(); ack_log.delete();
        set_req(0, 1'b1, 32'h04, 32'hA5); raise = cyc_n;
        wait_acks(1, 20, "wr_ack");
        chk("wr_latency", 64'(ack_cyc[0] - raise + 1), 64'd3);
        chk("wr_cs_count", 64'(cs_log.size()), 64'd1);
        chk("wr_cs_addr", 64'(cs_log[0]), 64'h04);
        chk("wr_mem", 64'(mem[1]), 64'hA5);
        drain(20);

        // Single read from requester 2.
        mem[2] = 32'h1234_5678;
        ack_log.delete();
        set_req(2, 1'b0, 32'h08, 32'h0); raise = cyc_n;
        wait_acks(1, 20, "rd_ack");
        chk("rd_latency", 64'(ack_cyc[2] - raise + 1), 64'd4);
        chk("rd_rvalid", 64'(rv_at_ack[2]), 64'b0100);
        chk("rd_rdata", 64'(bus.m_rdata), 64'h1234_5678);
        drain(20);

        // Fairness: everyone requests continuously after a fresh reset.
        rstn = 1'b0; tick(); tick(); rstn = 1'b1;
        ack_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            hold[i] = 1;
            set_req(i, 1'(i % 2), 32'(i * 4), 32'(i + 100));
        end
        wait_acks(8, 80, "fair_acks");
        for (int k = 0; k < 8; k++) chk("fair_order", 64'(ack_log[k]), 64'(exp_ord[k]));
        foreach (hold[i]) hold[i] = 0;
        drain(100);

        // Pointer wrap: last winner is 3, then 0 and 3 both request.
        ack_log.delete(); hold[0] = 1;
        set_req(0, 1'b1, 32'h30, 32'h5A);
        set_req(3, 1'b0, 32'h34, 32'h0);
        wait_acks(1, 20, "wrap1"); hold[0] = 0;
        wait_acks(2, 20, "wrap2");
        chk("wrap_first", 64'(ack_log[0]), 64'd0);
        chk("wrap_second", 64'(ack_log[1]), 64'd3);
        drain(40);

        // Reset during the read-data cycle.
        cs_log.delete(); ack_log.delete();
        set_req(1, 1'b0, 32'h0C, 32'h0);
        wait_cs(1, 20, "rst_cs");
        tick();
        rstn = 1'b0;
        tick(); tick();
        chk("rst_no_ack", 64'(ack_log.size()), 64'd0);
        chk("rst_rdata", 64'(bus.m_rdata), 64'd0);
        chk("rst_chipselect", 64'(bus.s_chipselect), 64'd0);
        rstn = 1'b1;
        set_req(0, 1'b1, 32'h00, 32'h11);
        set_req(2, 1'b0, 32'h08, 32'h0);
        set_req(3, 1'b1, 32'h3C, 32'h33);
        wait_acks(1, 20, "post_rst");
        chk("post_rst_first", 64'(ack_log[0]), 64'd0);
        drain(60);

        // Winner's address change during ACCESS is ignored; re-request uses it.
        cs_log.delete(); ack_log.delete(); hold[1] = 1;
        set_req(1, 1'b1, 32'h10, 32'h77);
        wait_cs(1, 20, "latch_cs1");
        bus.m_addr[1*AW +: AW] = 32'h20;
        wait_acks(1, 20, "latch_ack1"); hold[1] = 0;
        wait_cs(2, 20, "latch_cs2");
        chk("latch_addr1", 64'(cs_log[0]), 64'h10);
        chk("latch_addr2", 64'(cs_log[1]), 64'h20);
        drain(20);

        // Random traffic.
        rand_on = 1;
        repeat (1500) tick();
        rand_on = 0;
        foreach (hold[i]) hold[i] = 0;
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
